// File: rtl/alu_defs.sv
// Shared definitions for the ALU issue path.
// Contents: ALU control codes, main-decoder op classes, R-type funct codes
// and the issue-controller FSM state encoding.
package alu_defs;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  // Main-decoder op classes
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_SLT   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;

  // R-type funct field codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_VALID = 2'b10
  } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode-to-ALU issue bus.
// Upstream side: in_valid_i/in_ready_o handshake with alu_op_i, funct_i,
// src1_i, src2_i. Downstream side: out_valid_o/out_ready_i handshake with
// ctrl_o, src1_o, src2_o, illegal_o.
// master: the environment (decode stage + ALU); slave: the issue controller.
interface alu_issue_ctrl_if #(parameter int DW = 32);
  logic          in_valid_i;
  logic          in_ready_o;
  logic [2:0]    alu_op_i;
  logic [5:0]    funct_i;
  logic [DW-1:0] src1_i;
  logic [DW-1:0] src2_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [3:0]    ctrl_o;
  logic [DW-1:0] src1_o;
  logic [DW-1:0] src2_o;
  logic          illegal_o;

  modport master (
    output in_valid_i, alu_op_i, funct_i, src1_i, src2_i, out_ready_i,
    input  in_ready_o, out_valid_o, ctrl_o, src1_o, src2_o, illegal_o
  );

  modport slave (
    input  in_valid_i, alu_op_i, funct_i, src1_i, src2_i, out_ready_i,
    output in_ready_o, out_valid_o, ctrl_o, src1_o, src2_o, illegal_o
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder.
// Ports: alu_op (main-decoder class), funct (R-type funct field) ->
//        ctrl (4-bit ALU control), illegal (undecodable), is_mul (multiply).
// Undecodable inputs yield ctrl=AND code with illegal=1 and is_mul=0.
module alu_ctrl_decode
  import alu_defs::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctrl,
  output logic       illegal,
  output logic       is_mul
);

  always_comb begin
    ctrl    = ALU_AND;
    illegal = 1'b0;
    is_mul  = 1'b0;
    case (alu_op)
      OP_ADD: ctrl = ALU_ADD;
      OP_SUB: ctrl = ALU_SUB;
      OP_SLT: ctrl = ALU_SLT;
      OP_OR:  ctrl = ALU_OR;
      OP_AND: ctrl = ALU_AND;
      OP_RTYPE: begin
        case (funct)
          FN_ADD: ctrl = ALU_ADD;
          FN_SUB: ctrl = ALU_SUB;
          FN_AND: ctrl = ALU_AND;
          FN_OR:  ctrl = ALU_OR;
          FN_NOR: ctrl = ALU_NOR;
          FN_SLT: ctrl = ALU_SLT;
          FN_MUL: begin
            ctrl   = ALU_MUL;
            is_mul = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-entry issue buffer between decode and the ALU.
// Ports: clk_i (rising edge), rst_i (synchronous, active-high),
//        bus (alu_issue_ctrl_if.slave): upstream valid/ready + decoded fields
//        and operands in, registered ALU control/operands + valid/ready out.
// Multiply ops are held MUL_LAT cycles (1..15) from accept to out_valid_o.
//
// state    | meaning
// ST_IDLE  | buffer empty, ready to accept
// ST_WAIT  | multiply captured, counting down until the multiplier settles
// ST_VALID | op presented to the ALU, held until out_ready_i
module alu_issue_ctrl
  import alu_defs::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DW      = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  alu_issue_ctrl_if.slave bus
);

  localparam bit         MUL_WAIT = (MUL_LAT > 1);
  localparam logic [3:0] LAT_LOAD = 4'(MUL_LAT - 1);

  issue_state_e  state, state_n;
  logic [3:0]    cnt;
  logic [3:0]    ctrl_q;
  logic          illegal_q;
  logic [DW-1:0] src1_q, src2_q;

  logic [3:0]    dec_ctrl;
  logic          dec_illegal;
  logic          dec_mul;
  logic          in_ready;
  logic          accept;

  alu_ctrl_decode u_decode (
    .alu_op  (bus.alu_op_i),
    .funct   (bus.funct_i),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .is_mul  (dec_mul)
  );

  assign accept = bus.in_valid_i && in_ready;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_n = (dec_mul && MUL_WAIT) ? ST_WAIT : ST_VALID;
      end
      ST_WAIT: begin
        if (cnt == 4'd1) state_n = ST_VALID;
      end
      ST_VALID: begin
        if (bus.out_ready_i) begin
          if (accept) state_n = (dec_mul && MUL_WAIT) ? ST_WAIT : ST_VALID;
          else        state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output logic; ready is combinational on out_ready_i so a drain and a
  // new accept can share one cycle.
  always_comb begin
    in_ready        = (state == ST_IDLE) || ((state == ST_VALID) && bus.out_ready_i);
    bus.out_valid_o = (state == ST_VALID);
  end

  assign bus.in_ready_o = in_ready;

  // Multiply settle counter
  always_ff @(posedge clk_i) begin
    if (rst_i)                              cnt <= 4'd0;
    else if (accept && dec_mul && MUL_WAIT) cnt <= LAT_LOAD;
    else if (state == ST_WAIT)              cnt <= cnt - 4'd1;
  end

  // Issue register set; loads only on accept, never cleared on drain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q    <= ALU_AND;
      illegal_q <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
    end else if (accept) begin
      ctrl_q    <= dec_ctrl;
      illegal_q <= dec_illegal;
      src1_q    <= bus.src1_i;
      src2_q    <= bus.src2_i;
    end
  end

  assign bus.ctrl_o    = ctrl_q;
  assign bus.illegal_o = illegal_q;
  assign bus.src1_o    = src1_q;
  assign bus.src2_o    = src2_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench: two instances (MUL_LAT=4 and MUL_LAT=1) see the same
// stimulus; accepted ops are pushed with their due cycle, a negedge monitor
// checks valid/ready every cycle and pops on drain.
module tb_alu_issue_ctrl;

  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  typedef struct {
    logic [3:0]  ctrl;
    logic        ill;
    logic [31:0] s1;
    logic [31:0] s2;
    int          avail;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic [2:0] legal_ops[5] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
  logic [5:0] legal_fns[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b100111, 6'b101010, 6'b011000};

  alu_issue_ctrl_if #(.DW(32)) ifa ();
  alu_issue_ctrl_if #(.DW(32)) ifb ();

  alu_issue_ctrl #(.MUL_LAT(LAT_A), .DW(32)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa.slave));
  alu_issue_ctrl #(.MUL_LAT(LAT_B), .DW(32)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  // Reference decode straight from the control-code tables.
  task automatic ref_decode(input logic [2:0] op, input logic [5:0] f,
                            output logic [3:0] c, output logic ill, output logic mul);
    c = 4'b0000; ill = 1'b0; mul = 1'b0;
    if      (op == 3'b000) c = 4'b0010;
    else if (op == 3'b001) c = 4'b0110;
    else if (op == 3'b011) c = 4'b0111;
    else if (op == 3'b100) c = 4'b0001;
    else if (op == 3'b101) c = 4'b0000;
    else if (op == 3'b010) begin
      if      (f == 6'b100000) c = 4'b0010;
      else if (f == 6'b100010) c = 4'b0110;
      else if (f == 6'b100100) c = 4'b0000;
      else if (f == 6'b100101) c = 4'b0001;
      else if (f == 6'b100111) c = 4'b0101;
      else if (f == 6'b101010) c = 4'b0111;
      else if (f == 6'b011000) begin c = 4'b1000; mul = 1'b1; end
      else ill = 1'b1;
    end else ill = 1'b1;
  endtask

  // One stimulus cycle: drive after the edge, then record accepted ops.
  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic r);
    logic [3:0] c;
    logic ill, mul;
    exp_t e;
    @(posedge clk); #1;
    rst = r;
    ifa.in_valid_i = v; ifa.alu_op_i = op; ifa.funct_i = f;
    ifa.src1_i = a; ifa.src2_i = b; ifa.out_ready_i = ordy;
    ifb.in_valid_i = v; ifb.alu_op_i = op; ifb.funct_i = f;
    ifb.src1_i = a; ifb.src2_i = b; ifb.out_ready_i = ordy;
    #1;
    if (!r && v) begin
      ref_decode(op, f, c, ill, mul);
      e.ctrl = c; e.ill = ill; e.s1 = a; e.s2 = b; e.acc = cyc;
      if (ifa.in_ready_o) begin e.avail = cyc + (mul ? LAT_A : 1); qa.push_back(e); end
      if (ifb.in_ready_o) begin e.avail = cyc + (mul ? LAT_B : 1); qb.push_back(e); end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic mon(input int k);
    logic rdy, vld, ordy, ill;
    logic [3:0] c;
    logic [31:0] s1, s2;
    exp_t f;
    bit old, vis;
    old = 1'b0;
    if (k == 0) begin
      rdy = ifa.in_ready_o; vld = ifa.out_valid_o; ordy = ifa.out_ready_i;
      c = ifa.ctrl_o; ill = ifa.illegal_o; s1 = ifa.src1_o; s2 = ifa.src2_o;
      if (qa.size() > 0 && qa[0].acc < cyc) begin old = 1'b1; f = qa[0]; end
    end else begin
      rdy = ifb.in_ready_o; vld = ifb.out_valid_o; ordy = ifb.out_ready_i;
      c = ifb.ctrl_o; ill = ifb.illegal_o; s1 = ifb.src1_o; s2 = ifb.src2_o;
      if (qb.size() > 0 && qb[0].acc < cyc) begin old = 1'b1; f = qb[0]; end
    end
    vis = old && (cyc >= f.avail);
    chk($sformatf("out_valid[%0d]", k), {63'd0, vld}, {63'd0, vis});
    chk($sformatf("in_ready[%0d]", k), {63'd0, rdy}, {63'd0, (!old || (vis && ordy))});
    if (vis && vld) begin
      chk($sformatf("ctrl[%0d]", k), {60'd0, c}, {60'd0, f.ctrl});
      chk($sformatf("illegal[%0d]", k), {63'd0, ill}, {63'd0, f.ill});
      chk($sformatf("src1[%0d]", k), {32'd0, s1}, {32'd0, f.s1});
      chk($sformatf("src2[%0d]", k), {32'd0, s2}, {32'd0, f.s2});
      if (ordy) begin
        if (k == 0) qa.delete(0);
        else        qb.delete(0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      mon(0);
      mon(1);
    end
  end

  task automatic rand_op(output logic [2:0] op, output logic [5:0] f);
    int r;
    r = $urandom_range(0, 9);
    f = 6'($urandom);
    if (r < 4)      op = legal_ops[$urandom_range(0, 4)];
    else if (r < 8) begin op = 3'b010; f = legal_fns[$urandom_range(0, 6)]; end
    else if (r == 8) op = 3'($urandom_range(6, 7));
    else            op = 3'b010;
  endtask

  initial begin
    logic [2:0] op;
    logic [5:0] f;
    ifa.in_valid_i = 1'b0; ifa.alu_op_i = '0; ifa.funct_i = '0;
    ifa.src1_i = '0; ifa.src2_i = '0; ifa.out_ready_i = 1'b0;
    ifb.in_valid_i = 1'b0; ifb.alu_op_i = '0; ifb.funct_i = '0;
    ifb.src1_i = '0; ifb.src2_i = '0; ifb.out_ready_i = 1'b0;

    // Reset for two cycles with an op offered
    drive(1'b1, 3'b000, 6'd0, 32'd9, 32'd9, 1'b1, 1'b1);
    drive(1'b1, 3'b000, 6'd0, 32'd9, 32'd9, 1'b1, 1'b1);
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("rst_ctrl_a", {60'd0, ifa.ctrl_o}, 64'd0);
    chk("rst_src1_a", {32'd0, ifa.src1_o}, 64'd0);
    chk("rst_src2_a", {32'd0, ifa.src2_o}, 64'd0);
    chk("rst_ill_a", {63'd0, ifa.illegal_o}, 64'd0);
    chk("rst_ready_a", {63'd0, ifa.in_ready_o}, 64'd1);
    chk("rst_ctrl_b", {60'd0, ifb.ctrl_o}, 64'd0);

    // R-type stream at one op per cycle
    drive(1'b1, 3'b010, 6'b100000, 32'd5, 32'd3, 1'b1, 1'b0);
    drive(1'b1, 3'b010, 6'b100010, 32'd5, 32'd3, 1'b1, 1'b0);
    drive(1'b1, 3'b010, 6'b101010, 32'd5, 32'd3, 1'b1, 1'b0);
    drive(1'b1, 3'b010, 6'b100111, 32'd5, 32'd3, 1'b1, 1'b0);
    idle(3);

    // Multiply latency
    drive(1'b1, 3'b010, 6'b011000, 32'd7, 32'd6, 1'b1, 1'b0);
    idle(6);

    // Backpressure then drain+accept in one cycle
    drive(1'b1, 3'b000, 6'd0, 32'd11, 32'd22, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 3'b100, 6'd0, 32'd1, 32'd2, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 6'd0, 32'd33, 32'd44, 1'b1, 1'b0);
    idle(3);

    // Illegal decodes followed by a legal op
    drive(1'b1, 3'b111, 6'd0, 32'd1, 32'd1, 1'b1, 1'b0);
    drive(1'b1, 3'b010, 6'b000000, 32'd2, 32'd2, 1'b1, 1'b0);
    drive(1'b1, 3'b101, 6'd0, 32'd3, 32'd3, 1'b1, 1'b0);
    idle(3);

    // Reset in the second WAIT cycle of a multiply
    drive(1'b1, 3'b010, 6'b011000, 32'd8, 32'd9, 1'b1, 1'b0);
    idle(1);
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(6);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      rand_op(op, f);
      drive(($urandom_range(0, 3) != 0), op, f, $urandom, $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
    end

    idle(20);
    chk("drained_a", 64'(qa.size()), 64'd0);
    chk("drained_b", 64'(qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
